// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback buffer.
package wb_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_buffer_fwd_match.sv
// Forwarding lookup: scans buffered entries oldest to youngest so the youngest match wins.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [PW-1:0]         head,
    input  logic [AW-1:0]         addr,
    output logic                  hit,
    output logic [XLEN-1:0]       data
);

    logic [PW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + i[PW-1:0];
            if (addr != REG_ZERO && entries[idx].valid && entries[idx].rd == addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_buffer.sv
// In-order writeback FIFO feeding the register file write port, with read-side forwarding.
// Optional same-cycle bypass into an empty buffer is enabled by defining WB_BYPASS_EN.
module regfile_writeback_buffer
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_rd,
    input  logic [XLEN-1:0] in_data,
    output logic            rf_we,
    output logic [AW-1:0]   rf_a3,
    output logic [XLEN-1:0] rf_wd,
    input  logic [AW-1:0]   q_a1,
    input  logic [AW-1:0]   q_a2,
    output logic            fwd_hit1,
    output logic [XLEN-1:0] fwd_data1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data2,
    output logic [CW-1:0]   count,
    output logic            empty,
    output logic            full
);

    wb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;

    logic push;
    logic pop;
    logic bypass;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign count    = count_q;

`ifdef WB_BYPASS_EN
    assign bypass = empty && in_valid && (in_rd != REG_ZERO);
`else
    assign bypass = 1'b0;
`endif

    assign pop  = !empty;
    assign push = in_valid && in_ready && (in_rd != REG_ZERO) && !bypass;

    // Write port is gated by reset so nothing queued leaks into the register file during a flush.
    always_comb begin
        rf_we = rst_n && (pop || bypass);
        rf_a3 = '0;
        rf_wd = '0;
        if (bypass) begin
            rf_a3 = in_rd;
            rf_wd = in_data;
        end else if (pop) begin
            rf_a3 = entries_q[head_q].rd;
            rf_wd = entries_q[head_q].data;
        end
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d = head_q + 1'b1;
        end
        if (push) begin
            entries_d[tail_q] = '{valid: 1'b1, rd: in_rd, data: in_data};
            tail_d = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (entries_q),
        .head    (head_q),
        .addr    (q_a1),
        .hit     (fwd_hit1),
        .data    (fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (entries_q),
        .head    (head_q),
        .addr    (q_a2),
        .hit     (fwd_hit2),
        .data    (fwd_data2)
    );

endmodule

// File: tb/tb_regfile_writeback_buffer.sv
// Bench for regfile_writeback_buffer: fixed vector table, directed corner sequences,
// a random stream, and a write-order scoreboard with a forwarding model.
module tb_regfile_writeback_buffer;
    import wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [AW-1:0]   in_rd = '0;
    logic [XLEN-1:0] in_data = '0;
    logic            rf_we;
    logic [AW-1:0]   rf_a3;
    logic [XLEN-1:0] rf_wd;
    logic [AW-1:0]   q_a1 = '0;
    logic [AW-1:0]   q_a2 = '0;
    logic            fwd_hit1, fwd_hit2;
    logic [XLEN-1:0] fwd_data1, fwd_data2;
    logic [CW-1:0]   count;
    logic            empty, full;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wr_t;

    wr_t sb[$];

    typedef struct {
        logic            v;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic [AW-1:0]   a1;
        logic [AW-1:0]   a2;
        logic            rdy;
        logic [CW-1:0]   cnt;
        logic            we;
        logic [AW-1:0]   a3;
        logic [XLEN-1:0] wd;
        logic            h1;
        logic [XLEN-1:0] d1;
        logic            h2;
        logic [XLEN-1:0] d2;
    } vec_t;

    vec_t tbl[9];

    regfile_writeback_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rd     (in_rd),
        .in_data   (in_data),
        .rf_we     (rf_we),
        .rf_a3     (rf_a3),
        .rf_wd     (rf_wd),
        .q_a1      (q_a1),
        .q_a2      (q_a2),
        .fwd_hit1  (fwd_hit1),
        .fwd_data1 (fwd_data1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data2 (fwd_data2),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_fwd(input logic [AW-1:0] addr, output logic hit,
                                      output logic [XLEN-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (addr != 0) begin
            foreach (sb[i]) begin
                if (sb[i].rd == addr) begin
                    hit  = 1'b1;
                    data = sb[i].data;
                end
            end
        end
    endfunction

    // Scoreboard monitor: before the edge, the queue mirrors the stored entries.
    always @(negedge clk) begin
        logic            eh;
        logic [XLEN-1:0] ed;
        wr_t             w;
        if (!rst_n) begin
            check("we_during_reset", 32'(rf_we), 32'd0);
            sb.delete();
        end else begin
            check("mon_count", 32'(count), 32'(sb.size()));
            check("mon_empty", 32'(empty), 32'(sb.size() == 0));
            check("mon_full", 32'(full), 32'(sb.size() == DEPTH));
            check("mon_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
            model_fwd(q_a1, eh, ed);
            check("mon_hit1", 32'(fwd_hit1), 32'(eh));
            check("mon_data1", fwd_data1, ed);
            model_fwd(q_a2, eh, ed);
            check("mon_hit2", 32'(fwd_hit2), 32'(eh));
            check("mon_data2", fwd_data2, ed);
`ifdef WB_BYPASS_EN
            if (in_valid && in_ready && in_rd != 0) sb.push_back('{in_rd, in_data});
`endif
            if (rf_we) begin
                if (sb.size() == 0) begin
                    check("spurious_write", 32'(rf_a3), 32'hFFFF_FFFF);
                end else begin
                    w = sb.pop_front();
                    check("wr_rd", 32'(rf_a3), 32'(w.rd));
                    check("wr_data", rf_wd, w.data);
                end
            end
`ifndef WB_BYPASS_EN
            if (in_valid && in_ready && in_rd != 0) sb.push_back('{in_rd, in_data});
`endif
        end
    end

    // Drives one cycle of inputs just after a posedge and returns at the following negedge.
    task automatic applyStimulus(input logic v, input logic [AW-1:0] rd, input logic [XLEN-1:0] data,
                                 input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        in_valid = v;
        in_rd    = rd;
        in_data  = data;
        q_a1     = a1;
        q_a2     = a2;
        @(negedge clk);
    endtask

    task automatic checkOutput(input int i, input vec_t e);
        check($sformatf("v%0d_ready", i), 32'(in_ready), 32'(e.rdy));
        check($sformatf("v%0d_count", i), 32'(count), 32'(e.cnt));
        check($sformatf("v%0d_we", i), 32'(rf_we), 32'(e.we));
        check($sformatf("v%0d_a3", i), 32'(rf_a3), 32'(e.a3));
        check($sformatf("v%0d_wd", i), rf_wd, e.wd);
        check($sformatf("v%0d_hit1", i), 32'(fwd_hit1), 32'(e.h1));
        check($sformatf("v%0d_data1", i), fwd_data1, e.d1);
        check($sformatf("v%0d_hit2", i), 32'(fwd_hit2), 32'(e.h2));
        check($sformatf("v%0d_data2", i), fwd_data2, e.d2);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd0, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        tbl[1] = '{1'b1, 5'd3, 32'hDEADBEEF,  5'd3, 5'd0, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        tbl[2] = '{1'b0, 5'd0, 32'h0,         5'd3, 5'd3, 1'b1, 3'd1, 1'b1, 5'd3, 32'hDEADBEEF,  1'b1, 32'hDEADBEEF,  1'b1, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 5'd0, 32'h0,         5'd3, 5'd0, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        tbl[4] = '{1'b1, 5'd7, 32'h1,         5'd7, 5'd7, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        tbl[5] = '{1'b1, 5'd7, 32'h2,         5'd7, 5'd0, 1'b1, 3'd1, 1'b1, 5'd7, 32'h1,         1'b1, 32'h1,         1'b0, 32'h0};
        tbl[6] = '{1'b0, 5'd0, 32'h0,         5'd7, 5'd7, 1'b1, 3'd1, 1'b1, 5'd7, 32'h2,         1'b1, 32'h2,         1'b1, 32'h2};
        tbl[7] = '{1'b1, 5'd0, 32'hFFFFFFFF,  5'd0, 5'd0, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        tbl[8] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd5, 1'b1, 3'd0, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};

        next_cycle();
        next_cycle();
        rst_n = 1'b1;

`ifndef WB_BYPASS_EN
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].v, tbl[i].rd, tbl[i].data, tbl[i].a1, tbl[i].a2);
            checkOutput(i, tbl[i]);
            next_cycle();
        end
`else
        // Bypass: an empty buffer writes the request straight through in the same cycle.
        applyStimulus(1'b1, 5'd9, 32'hA5, 5'd9, 5'd0);
        check("byp_we", 32'(rf_we), 32'd1);
        check("byp_a3", 32'(rf_a3), 32'd9);
        check("byp_wd", rf_wd, 32'hA5);
        check("byp_hit1", 32'(fwd_hit1), 32'd0);
        next_cycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
        check("byp_count_after", 32'(count), 32'd0);
        check("byp_we_after", 32'(rf_we), 32'd0);
        next_cycle();
`endif

        // Back-to-back stream: drain keeps pace so the buffer never fills.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, AW'(k), 32'h100 + 32'(k), AW'(k), AW'(k - 1));
            check($sformatf("b2b_ready%0d", k), 32'(in_ready), 32'd1);
            next_cycle();
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd4);
            next_cycle();
        end
        check("b2b_drained", 32'(sb.size()), 32'd0);

        // Reset while entries are in flight discards them.
        for (int k = 10; k <= 12; k++) begin
            applyStimulus(1'b1, AW'(k), 32'hC000 + 32'(k), 5'd12, 5'd11);
            next_cycle();
        end
        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 5'd0);
        next_cycle();
        rst_n = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 5'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_hit1", 32'(fwd_hit1), 32'd0);
        next_cycle();

        // Random traffic including x0 requests, checked by the scoreboard monitor.
        for (int k = 0; k < 60; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
            next_cycle();
        end
        check("final_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
